// File: rtl/id_counter_param_pkg.sv
// Shared DPLL defaults and the period-length selector used by the I/D counter.
package id_counter_param_pkg;

    localparam int unsigned DPLL_DIV_N       = 4;
    localparam int unsigned DPLL_PEND_W      = 4;
    localparam int unsigned DPLL_SYNC_STAGES = 2;

    // Which period length is in force for the current output period.
    typedef enum logic [1:0] {
        TERM_NOM   = 2'd0,
        TERM_SHORT = 2'd1,
        TERM_LONG  = 2'd2
    } term_sel_e;

endpackage

// File: rtl/id_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector; one pulse per input rise.
module id_sync_edge
    import id_counter_param_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DPLL_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        last_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/id_counter_param.sv
// DPLL increment/decrement counter: divides clk by DIV_N, shortening or lengthening one
// period per queued correction held in a saturating signed accumulator.
module id_counter_param
    import id_counter_param_pkg::*;
#(
    parameter int unsigned DIV_N       = DPLL_DIV_N,
    parameter int unsigned PEND_W      = DPLL_PEND_W,
    parameter int unsigned SYNC_STAGES = DPLL_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     dec,
    input  logic                     en,
    output logic                     id_out,
    output logic                     id_clk,
    output logic signed [PEND_W-1:0] pend,
    output logic                     sat
);

    localparam int unsigned CNT_W    = $clog2(DIV_N + 1);
    localparam int          PEND_MAX = (1 << (PEND_W - 1)) - 1;
    localparam int          PEND_MIN = -PEND_MAX - 1;

    logic                     inc_p, dec_p;
    logic [CNT_W-1:0]         cnt_q, cnt_d, term_val;
    term_sel_e                term_q, term_d;
    logic signed [PEND_W-1:0] pend_q, pend_d;
    logic                     id_out_q, id_out_d;
    logic                     id_clk_q, id_clk_d;
    logic                     sat_q, sat_d;
    int                       consume;
    int                       pend_sum;

    id_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
        .clk   (clk),
        .reset (reset),
        .d     (inc),
        .pulse (inc_p)
    );

    id_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dec (
        .clk   (clk),
        .reset (reset),
        .d     (dec),
        .pulse (dec_p)
    );

    always_comb begin
        case (term_q)
            TERM_SHORT: term_val = CNT_W'(DIV_N - 2);
            TERM_LONG:  term_val = CNT_W'(DIV_N);
            default:    term_val = CNT_W'(DIV_N - 1);
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        term_d   = term_q;
        id_out_d = 1'b0;
        id_clk_d = id_clk_q;
        consume  = 0;
        if (en) begin
            if (cnt_q == term_val) begin
                cnt_d    = '0;
                id_out_d = 1'b1;
                id_clk_d = ~id_clk_q;
                // Next period's length is chosen from pend before this cycle's events land.
                if (pend_q[PEND_W-1]) begin
                    term_d  = TERM_LONG;
                    consume = -1;
                end else if (pend_q != '0) begin
                    term_d  = TERM_SHORT;
                    consume = 1;
                end else begin
                    term_d  = TERM_NOM;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        pend_sum = int'(pend_q) + int'(inc_p) - int'(dec_p) - consume;
        sat_d    = 1'b0;
        if (pend_sum > PEND_MAX) begin
            pend_sum = PEND_MAX;
            sat_d    = 1'b1;
        end else if (pend_sum < PEND_MIN) begin
            pend_sum = PEND_MIN;
            sat_d    = 1'b1;
        end
        pend_d = PEND_W'(pend_sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            term_q   <= TERM_NOM;
            pend_q   <= '0;
            id_out_q <= 1'b0;
            id_clk_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            term_q   <= term_d;
            pend_q   <= pend_d;
            id_out_q <= id_out_d;
            id_clk_q <= id_clk_d;
            sat_q    <= sat_d;
        end
    end

    assign id_out = id_out_q;
    assign id_clk = id_clk_q;
    assign pend   = pend_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_id_counter_param.sv
// Bench for id_counter_param: period-length reference model plus directed literal checks.
module tb_id_counter_param;

    localparam int unsigned DIV_N  = 4;
    localparam int unsigned PEND_W = 4;
    localparam int unsigned SYNC   = 2;
    localparam int          PMAX   = 7;
    localparam int          PMIN   = -8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic en = 1'b0;
    logic id_out, id_clk, sat;
    logic signed [PEND_W-1:0] pend;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int        m_pend, m_elapsed, m_len, m_c, m_nxt;
    bit        m_id_out, m_id_clk, m_sat, m_ei, m_ed;
    bit [SYNC:0] inc_hist, dec_hist;
    int        sat_seen, out_while_off, pend_peak;

    id_counter_param #(
        .DIV_N       (DIV_N),
        .PEND_W      (PEND_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc),
        .dec    (dec),
        .en     (en),
        .id_out (id_out),
        .id_clk (id_clk),
        .pend   (pend),
        .sat    (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each output period lasts a whole number of enabled cycles chosen at the wrap.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_pend = 0; m_elapsed = 0; m_len = DIV_N;
                m_id_out = 0; m_id_clk = 0; m_sat = 0;
                inc_hist = '0; dec_hist = '0;
            end else begin
                m_ei = inc_hist[SYNC-1] && !inc_hist[SYNC];
                m_ed = dec_hist[SYNC-1] && !dec_hist[SYNC];
                inc_hist = {inc_hist[SYNC-1:0], inc};
                dec_hist = {dec_hist[SYNC-1:0], dec};
                m_c = 0;
                m_id_out = 0;
                if (en) begin
                    m_elapsed++;
                    if (m_elapsed == m_len) begin
                        m_elapsed = 0;
                        m_id_out = 1;
                        m_id_clk = !m_id_clk;
                        if (m_pend > 0) begin m_len = DIV_N - 1; m_c = 1; end
                        else if (m_pend < 0) begin m_len = DIV_N + 1; m_c = -1; end
                        else m_len = DIV_N;
                    end
                end
                m_nxt = m_pend + int'(m_ei) - int'(m_ed) - m_c;
                m_sat = (m_nxt > PMAX) || (m_nxt < PMIN);
                if (m_nxt > PMAX) m_nxt = PMAX;
                if (m_nxt < PMIN) m_nxt = PMIN;
                m_pend = m_nxt;
            end
            #1;
            check("id_out", int'(id_out), int'(m_id_out));
            check("id_clk", int'(id_clk), int'(m_id_clk));
            check("pend",   int'(pend),   m_pend);
            check("sat",    int'(sat),    int'(m_sat));
            if (sat) sat_seen++;
            if (id_out && !en) out_while_off++;
            if (int'(pend) > pend_peak) pend_peak = int'(pend);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit do_inc, input bit do_dec);
        @(negedge clk);
        inc = do_inc;
        dec = do_dec;
        tick(3);
        inc = 1'b0;
        dec = 1'b0;
        tick(3);
    endtask

    // Cycles until the next id_out pulse, bounded.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!id_out && n < 40);
        if (!id_out) check("id_out_timeout", 0, 1);
    endtask

    int p;

    initial begin
        // Reset state
        tick(3);
        check("rst_id_out", int'(id_out), 0);
        check("rst_id_clk", int'(id_clk), 0);
        check("rst_pend",   int'(pend),   0);
        check("rst_sat",    int'(sat),    0);
        reset = 1'b1;
        en    = 1'b1;
        wait_out(p); check("first_period", p, 4);
        wait_out(p); check("nominal_period_a", p, 4);
        wait_out(p); check("nominal_period_b", p, 4);

        // Single inc: pend reaches +1 three clocks after the edge
        @(negedge clk); inc = 1'b1;
        repeat (2) @(posedge clk);
        #1; check("inc_pend_early", int'(pend), 0);
        @(posedge clk);
        #1; check("inc_pend_latency", int'(pend), 1);
        @(negedge clk); inc = 1'b0;
        wait_out(p);
        wait_out(p); check("inc_short_period", p, 3);
        wait_out(p); check("inc_after_period", p, 4);
        check("inc_pend_drained", int'(pend), 0);

        // Single dec
        @(negedge clk); dec = 1'b1;
        repeat (3) @(posedge clk);
        #1; check("dec_pend_latency", int'(pend), -1);
        @(negedge clk); dec = 1'b0;
        wait_out(p);
        wait_out(p); check("dec_long_period", p, 5);
        wait_out(p); check("dec_after_period", p, 4);
        check("dec_pend_drained", int'(pend), 0);

        // 3 inc then 2 dec with the period counter held
        @(negedge clk); en = 1'b0; pend_peak = 0;
        repeat (3) pulse(1'b1, 1'b0);
        repeat (2) pulse(1'b0, 1'b1);
        check("mix_peak", pend_peak, 3);
        check("mix_settle", int'(pend), 1);
        @(negedge clk); en = 1'b1;
        wait_out(p);
        wait_out(p); check("mix_short_period", p, 3);
        wait_out(p); check("mix_after_period", p, 4);

        // Simultaneous inc and dec cancel
        pulse(1'b1, 1'b1);
        check("cancel_pend", int'(pend), 0);
        wait_out(p);
        wait_out(p); check("cancel_period", p, 4);

        // Saturation with counter disabled
        @(negedge clk); en = 1'b0; sat_seen = 0; out_while_off = 0;
        repeat (9) pulse(1'b1, 1'b0);
        check("sat_pend", int'(pend), 7);
        check("sat_pulses", sat_seen, 2);
        check("sat_no_out", out_while_off, 0);
        @(negedge clk); en = 1'b1;
        wait_out(p);
        for (int i = 0; i < 7; i++) begin
            wait_out(p); check("sat_drain_period", p, 3);
        end
        wait_out(p); check("sat_final_period", p, 4);
        check("sat_pend_drained", int'(pend), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) inc = ~inc;
            if ($urandom_range(0, 2) == 0) dec = ~dec;
            en = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk); inc = 1'b0; dec = 1'b0; en = 1'b1;
        tick(80);
        check("random_drained", int'(pend), 0);

        // Reset mid-period with pend = -3
        @(negedge clk); en = 1'b0;
        repeat (3) pulse(1'b0, 1'b1);
        check("pre_reset_pend", int'(pend), -3);
        @(negedge clk); en = 1'b1;
        tick(2);
        reset = 1'b0;
        #1;
        check("midrst_id_out", int'(id_out), 0);
        check("midrst_id_clk", int'(id_clk), 0);
        check("midrst_pend",   int'(pend),   0);
        check("midrst_sat",    int'(sat),    0);
        tick(3);
        reset = 1'b1;
        wait_out(p); check("post_reset_first_out", p, 4);
        check("post_reset_pend", int'(pend), 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
